// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter_pkg
//  Purpose  : Shared state encodings, requester IDs and sizing helper for the
//             memory-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_GRANT_IF = 2'd1,
      ST_GRANT_LS = 2'd2,
      ST_RELEASE  = 2'd3
   } arb_state_t;

   // Requester IDs (bit positions in the request/grant vectors)
   localparam logic c_REQ_IF = 1'b0;
   localparam logic c_REQ_LS = 1'b1;

   // Wait counter width: clog2(max_wait+1), never narrower than one bit
   function automatic int wait_cnt_width(input int max_wait);
      int w;
      w = $clog2(max_wait + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage : mem_port_arbiter_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Combinational two-way round-robin pick. A lone request wins;
//             on a tie the requester that did not win last time is chosen.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arb2
   import mem_port_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // One-hot grant from the request pair and the previous winner
   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == c_REQ_LS) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one memory-controller port between instruction fetch
//             (read-only) and load/store (read/write). Latches the winning
//             request, drives the memory port and returns ack/data/err to the
//             winner only.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_WAIT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_en,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_do,
   output logic              if_ack,
   input  logic              ls_en,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_di,
   output logic [DATA_W-1:0] ls_do,
   output logic              ls_ack,
   output logic              ls_err,
   output logic              if_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_di,
   input  logic [DATA_W-1:0] mem_do,
   input  logic              mem_do_ack,
   output logic              busy
);

   localparam int                 c_CNT_W       = wait_cnt_width(MAX_WAIT);
   localparam bit                 c_TIMEOUT_EN  = (MAX_WAIT > 0);
   localparam logic [c_CNT_W-1:0] c_WAIT_LAST   = c_TIMEOUT_EN ? c_CNT_W'(MAX_WAIT - 1) : '0;
   localparam logic [c_CNT_W-1:0] c_CNT_MAX     = '1;

   arb_state_t          r_state;
   logic                r_last_grant;
   logic [c_CNT_W-1:0]  r_wait_cnt;
   logic                r_mem_en;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_di;
   logic                r_busy;

   logic [1:0]          w_gnt;
   logic                w_in_grant;
   logic                w_ack;
   logic                w_timeout;

   rr_arb2 u_rr_arb2 (
      .req  ({ls_en, if_en}),
      .last (r_last_grant),
      .gnt  (w_gnt)
   );

   // Completion and abort are only recognised while a grant is held; a
   // reset in progress suppresses them so the in-flight request gets nothing.
   assign w_in_grant = (r_state == ST_GRANT_IF) || (r_state == ST_GRANT_LS);
   assign w_ack      = w_in_grant && mem_do_ack && !reset;
   assign w_timeout  = c_TIMEOUT_EN && w_in_grant && !mem_do_ack && !reset &&
                       (r_wait_cnt == c_WAIT_LAST);

   assign if_ack = w_ack     && (r_state == ST_GRANT_IF);
   assign ls_ack = w_ack     && (r_state == ST_GRANT_LS);
   assign if_err = w_timeout && (r_state == ST_GRANT_IF);
   assign ls_err = w_timeout && (r_state == ST_GRANT_LS);
   assign if_do  = if_ack ? mem_do : '0;
   assign ls_do  = ls_ack ? mem_do : '0;

   assign mem_en   = r_mem_en;
   assign mem_we   = r_mem_we;
   assign mem_addr = r_mem_addr;
   assign mem_di   = r_mem_di;
   assign busy     = r_busy;

   // Arbitration FSM with latched memory-port registers and wait counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= c_REQ_LS;
         r_wait_cnt   <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_di     <= '0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_gnt[0]) begin
                  r_state    <= ST_GRANT_IF;
                  r_mem_en   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_wait_cnt <= '0;
                  r_mem_addr <= if_addr;
                  r_mem_we   <= 1'b0;
                  r_mem_di   <= '0;
               end else if (w_gnt[1]) begin
                  r_state    <= ST_GRANT_LS;
                  r_mem_en   <= 1'b1;
                  r_busy     <= 1'b1;
                  r_wait_cnt <= '0;
                  r_mem_addr <= ls_addr;
                  r_mem_we   <= ls_we;
                  r_mem_di   <= ls_di;
               end
            end
            ST_GRANT_IF, ST_GRANT_LS: begin
               if (w_ack || w_timeout) begin
                  r_mem_en     <= 1'b0;
                  r_last_grant <= (r_state == ST_GRANT_LS) ? c_REQ_LS : c_REQ_IF;
                  r_state      <= ST_RELEASE;
               end else if (r_wait_cnt != c_CNT_MAX) begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end
            ST_RELEASE: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : mem_port_arbiter
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios
//             followed by randomized requests/ack delays against a
//             transaction-level model (round-robin rule plus a memory array).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 8;
   localparam int MAX_WAIT = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_en, if_ack, if_err;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_do;
   logic              ls_en, ls_we, ls_ack, ls_err;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_di, ls_do;
   logic              mem_en, mem_we, mem_do_ack, busy;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_di, mem_do;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .reset(reset),
      .if_en(if_en), .if_addr(if_addr), .if_do(if_do), .if_ack(if_ack),
      .ls_en(ls_en), .ls_we(ls_we), .ls_addr(ls_addr), .ls_di(ls_di),
      .ls_do(ls_do), .ls_ack(ls_ack), .ls_err(ls_err), .if_err(if_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
      .mem_do(mem_do), .mem_do_ack(mem_do_ack), .busy(busy)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model state
   logic [7:0] mem_arr [256];
   int         m_last;            // 0 = fetch won last, 1 = load/store won last
   bit         if_pend, ls_pend, ls_w;
   logic [7:0] if_a, ls_a, ls_d;
   int         if_wait, ls_wait;  // transactions a pending request has lost

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Round-robin rule: lone request wins, tie goes to whoever did not win last
   function automatic int pick(input bit a, input bit b, input int last);
      if (a && b) return (last == 1) ? 0 : 1;
      return a ? 0 : 1;
   endfunction

   task automatic apply_reqs();
      if_en   = if_pend;
      if_addr = if_a;
      ls_en   = ls_pend;
      ls_we   = ls_w;
      ls_addr = ls_a;
      ls_di   = ls_d;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_if_ack"}, if_ack, 0);
      check({tag, "_ls_ack"}, ls_ack, 0);
      check({tag, "_if_err"}, if_err, 0);
      check({tag, "_ls_err"}, ls_err, 0);
   endtask

   // One complete transaction from IDLE; memory answers `delay` cycles into
   // the grant, or never if delay >= MAX_WAIT (timeout expected).
   task automatic serve(input int delay);
      int         w;
      bit         ewe, acked;
      logic [7:0] ea, ed, rd;
      w     = pick(if_pend, ls_pend, m_last);
      ea    = (w == 0) ? if_a : ls_a;
      ewe   = (w == 0) ? 1'b0 : ls_w;
      ed    = (w == 0) ? 8'h00 : ls_d;
      acked = 1'b0;
      apply_reqs();
      tick();
      check("grant_mem_en", mem_en, 1);
      check("grant_busy", busy, 1);
      check("grant_mem_addr", mem_addr, ea);
      check("grant_mem_we", mem_we, ewe);
      check("grant_mem_di", mem_di, ed);
      for (int k = 0; k < MAX_WAIT; k++) begin
         if (k == delay) begin
            rd = ewe ? 8'($urandom) : mem_arr[ea];
            mem_do = rd;
            mem_do_ack = 1'b1;
            #1;
            check("ack_winner", (w == 0) ? if_ack : ls_ack, 1);
            check("ack_loser", (w == 0) ? ls_ack : if_ack, 0);
            check("do_winner", (w == 0) ? if_do : ls_do, rd);
            check("do_loser", (w == 0) ? ls_do : if_do, 0);
            check("ack_no_err", if_err | ls_err, 0);
            acked = 1'b1;
         end else if (k == MAX_WAIT - 1) begin
            mem_do = 8'($urandom);
            mem_do_ack = 1'b0;
            #1;
            check("err_winner", (w == 0) ? if_err : ls_err, 1);
            check("err_loser", (w == 0) ? ls_err : if_err, 0);
            check("err_no_ack", if_ack | ls_ack, 0);
         end else begin
            mem_do_ack = 1'b0;
            #1;
            check_quiet("wait");
            check("wait_mem_en", mem_en, 1);
            check("wait_mem_addr", mem_addr, ea);
         end
         tick();
         mem_do_ack = 1'b0;
         if (acked || k == MAX_WAIT - 1) break;
      end
      // Release cycle: stray acks must be ignored here
      check("rel_mem_en", mem_en, 0);
      check("rel_busy", busy, 1);
      mem_do_ack = 1'($urandom);
      #1;
      check_quiet("rel");
      if (acked && ewe) mem_arr[ea] = ed;
      m_last = w;
      if (w == 0) begin
         if_pend = 1'b0; if_wait = 0;
         if (ls_pend) begin ls_wait++; check("ls_served_within_2", ls_wait < 2, 1); end
      end else begin
         ls_pend = 1'b0; ls_wait = 0;
         if (if_pend) begin if_wait++; check("if_served_within_2", if_wait < 2, 1); end
      end
      apply_reqs();
      tick();
      mem_do_ack = 1'b0;
      check("idle_busy", busy, 0);
      check("idle_mem_en", mem_en, 0);
   endtask

   task automatic idle_step(input bit spurious);
      apply_reqs();
      mem_do_ack = spurious;
      mem_do = 8'($urandom);
      #1;
      check_quiet("idle");
      tick();
      mem_do_ack = 1'b0;
      check("idle_stay_busy", busy, 0);
      check("idle_stay_mem_en", mem_en, 0);
   endtask

   task automatic new_reqs();
      if (!if_pend && ($urandom_range(0, 2) != 0)) begin
         if_pend = 1'b1; if_a = 8'($urandom);
      end
      if (!ls_pend && ($urandom_range(0, 2) != 0)) begin
         ls_pend = 1'b1; ls_w = 1'($urandom); ls_a = 8'($urandom); ls_d = 8'($urandom);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
      mem_arr[8'h10] = 8'hA5;
      reset = 1'b1; mem_do_ack = 1'b0; mem_do = '0;
      if_pend = 0; ls_pend = 0; ls_w = 0; if_a = 0; ls_a = 0; ls_d = 0;
      if_wait = 0; ls_wait = 0; m_last = 1;
      apply_reqs();
      tick(); tick();
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_di", mem_di, 0);
      check("rst_if_do", if_do, 0);
      check("rst_ls_do", ls_do, 0);
      check_quiet("rst");
      reset = 1'b0;

      // Both requesting continuously from reset: fetch first, then alternate
      for (int i = 0; i < 4; i++) begin
         if (!if_pend) begin if_pend = 1; if_a = 8'($urandom); end
         if (!ls_pend) begin ls_pend = 1; ls_w = 1'($urandom); ls_a = 8'($urandom); ls_d = 8'($urandom); end
         serve(1);
      end
      if (if_pend) serve(0);
      if (ls_pend) serve(0);

      // Fetch only, memory answers two cycles into the grant
      if_pend = 1; if_a = 8'h10;
      serve(2);

      // Load/store write
      ls_pend = 1; ls_w = 1; ls_a = 8'h20; ls_d = 8'h3C;
      serve(1);

      // Memory never answers: abort, then a normal grant
      ls_pend = 1; ls_w = 0; ls_a = 8'h20;
      serve(MAX_WAIT + 1);
      if_pend = 1; if_a = 8'h20;
      serve(0);

      // Reset while fetch is granted; the fetch is then served afresh
      if_pend = 1; if_a = 8'h55;
      apply_reqs();
      tick();
      check("pre_rst_mem_en", mem_en, 1);
      reset = 1'b1;
      mem_do_ack = 1'b1;
      mem_do = 8'h77;
      #1;
      check("rst_mid_if_ack", if_ack, 0);
      tick();
      mem_do_ack = 1'b0;
      check("rst_mid_mem_en", mem_en, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_if_ack_after", if_ack, 0);
      reset = 1'b0;
      m_last = 1;
      serve(1);

      // Spurious ack while idle
      idle_step(1'b1);
      idle_step(1'b1);

      // Randomized traffic
      for (int n = 0; n < 150; n++) begin
         new_reqs();
         if (if_pend || ls_pend) serve(int'($urandom_range(0, MAX_WAIT + 1)));
         else idle_step(1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_mem_port_arbiter
`default_nettype wire
